uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_pick.sv | 39 +++
 rtl/uart_tx_arb.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit arbiter:
//     - arb_state_t : arbiter FSM state encoding (IDLE / GRANT)
//     - BYTE_W      : width of one transmitted byte
//     - CNT_W       : width of the burst and idle counters
//     - ID_W        : width of a requester index (up to 8 requesters)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;
    localparam int ID_W   = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Cyclic first-one search: returns the first set bit of `valid` found by
//   scanning upward from position `ptr`, wrapping past N_REQ-1 back to 0.
//
//   Ports
//     valid : in  [N_REQ-1:0]  candidate vector
//     ptr   : in  [ID_W-1:0]   search start position (expected < N_REQ)
//     idx   : out [ID_W-1:0]   selected index (0 when nothing is found)
//     found : out              high when any valid bit is set
// ---------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    // The outer loop walks search distance from ptr, so the nearest candidate
    // wins. The inner loop only compares against constant positions, which
    // keeps every select of `valid` a constant index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && valid[i] && (i == ((int'(ptr) + k) % N_REQ))) begin
                    idx   = ID_W'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//   Round-robin arbiter that lets N_REQ byte-stream requesters share one UART
//   transmitter enqueue port. A grant is held for a whole message (until the
//   byte flagged `last` is accepted) unless the requester either sends
//   MAX_BURST bytes or leaves its valid low for IDLE_TO cycles mid-message;
//   then the grant is released and the requester re-arbitrates later without
//   losing any byte. The granted stream is passed through combinationally.
//
//   Ports
//     clk          : in   rising-edge clock
//     reset        : in   asynchronous reset, active low
//     io_req_valid : in   [N_REQ-1:0]   per-requester byte valid
//     io_req_bits  : in   [N_REQ*8-1:0] per-requester byte, slice [8i+7:8i]
//     io_req_last  : in   [N_REQ-1:0]   final byte of a message
//     io_req_ready : out  [N_REQ-1:0]   per-requester accept
//     io_enq_valid : out  byte valid toward the transmitter
//     io_enq_bits  : out  [7:0] byte toward the transmitter
//     io_enq_ready : in   transmitter accept
//     io_gnt_valid : out  high while a grant is held
//     io_gnt_id    : out  [2:0] granted requester, 0 when none
// ---------------------------------------------------------------------------
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int IDLE_TO   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          io_req_valid,
    input  logic [N_REQ*BYTE_W-1:0]   io_req_bits,
    input  logic [N_REQ-1:0]          io_req_last,
    output logic [N_REQ-1:0]          io_req_ready,
    output logic                      io_enq_valid,
    output logic [BYTE_W-1:0]         io_enq_bits,
    input  logic                      io_enq_ready,
    output logic                      io_gnt_valid,
    output logic [2:0]                io_gnt_id
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] IDLE_LIM  = CNT_W'(IDLE_TO);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

    arb_state_t        state;
    logic [ID_W-1:0]   gnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  idle_cnt;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_found;

    logic              sel_valid;
    logic              sel_last;
    logic [BYTE_W-1:0] sel_bits;

    logic              in_grant;
    logic              accept;
    logic              burst_done;
    logic              idle_done;
    logic              release_now;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .valid (io_req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Pick out the granted requester's lane. Comparing against each constant
    // index avoids a variable select whose width differs from the vector.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_bits  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt == ID_W'(i)) begin
                sel_valid = io_req_valid[i];
                sel_last  = io_req_last[i];
                sel_bits  = io_req_bits[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign in_grant = (state == ST_GRANT);
    assign accept   = in_grant && sel_valid && io_enq_ready;

    // Both limits are tested against the pre-increment count so the release
    // happens on the very edge that accepts the limiting beat / idle cycle.
    assign burst_done = accept && (burst_cnt == BURST_LIM - 1'b1);
    assign idle_done  = in_grant && !sel_valid && (idle_cnt == IDLE_LIM - 1'b1);

    // A single OR term: last and burst limit on the same beat still yield
    // exactly one release.
    assign release_now = (accept && (sel_last || burst_done)) || idle_done;

    // Outputs are forced to zero outside GRANT, so only the granted lane can
    // ever reach the transmitter or see a ready.
    always_comb begin
        io_enq_valid = in_grant && sel_valid;
        io_enq_bits  = in_grant ? sel_bits : '0;
        io_req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in_grant && (gnt == ID_W'(i))) begin
                io_req_ready[i] = io_enq_ready;
            end
        end
    end

    assign io_gnt_valid = in_grant;
    assign io_gnt_id    = in_grant ? gnt : '0;

    // ---- arbitration / grant state ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        gnt   <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state     <= ST_IDLE;
                        rr_ptr    <= (gnt == LAST_ID) ? '0 : gnt + 1'b1;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                    end else if (accept) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        idle_cnt  <= '0;
                    end else if (!sel_valid) begin
                        // Back-pressure with valid high is not idleness.
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//   Directed bench for uart_tx_arb (N_REQ=4, MAX_BURST=16, IDLE_TO=64).
//   Inputs change 2 ns after a rising edge, outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_bits;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        enq_valid;
    logic [7:0]  enq_bits;
    logic        enq_ready;
    logic        gnt_valid;
    logic [2:0]  gnt_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .N_REQ     (4),
        .MAX_BURST (16),
        .IDLE_TO   (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_req_valid (req_valid),
        .io_req_bits  (req_bits),
        .io_req_last  (req_last),
        .io_req_ready (req_ready),
        .io_enq_valid (enq_valid),
        .io_enq_bits  (enq_bits),
        .io_enq_ready (enq_ready),
        .io_gnt_valid (gnt_valid),
        .io_gnt_id    (gnt_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input int i, input logic v, input logic [7:0] b, input logic l);
        req_valid[i]       = v;
        req_bits[i*8 +: 8] = b;
        req_last[i]        = l;
    endtask

    task automatic idle_outs(input string tag);
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, ".gnt_id"},    32'(gnt_id),    32'd0);
        check({tag, ".enq_valid"}, 32'(enq_valid), 32'd0);
        check({tag, ".enq_bits"},  32'(enq_bits),  32'd0);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic grant_outs(input string tag, input int id, input logic [7:0] b,
                              input logic [3:0] rdy);
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'd1);
        check({tag, ".gnt_id"},    32'(gnt_id),    32'(id));
        check({tag, ".enq_valid"}, 32'(enq_valid), 32'd1);
        check({tag, ".enq_bits"},  32'(enq_bits),  32'(b));
        check({tag, ".req_ready"}, 32'(rdy),       32'(rdy) & 32'(req_ready) | 32'(rdy));
        check({tag, ".req_ready_eq"}, 32'(req_ready), 32'(rdy));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] rdy;
        int         id;

        // ---- reset: outputs zero even with a requester valid ----
        reset     = 1'b0;
        req_valid = '0;
        req_bits  = '0;
        req_last  = '0;
        enq_ready = 1'b1;
        put(1, 1'b1, 8'h5A, 1'b1);
        #1;
        idle_outs("rst_async");
        tick();
        tick();
        idle_outs("rst_held");
        reset = 1'b1;
        #1;
        idle_outs("rst_release");
        req_valid = '0;
        req_bits  = '0;
        req_last  = '0;
        tick();

        // ---- single requester 2: 0x41 0x42 0x43(last) ----
        put(2, 1'b1, 8'h41, 1'b0);
        #1;
        idle_outs("t1_pre");
        tick();
        grant_outs("t1_b0", 2, 8'h41, 4'b0100);
        tick();
        put(2, 1'b1, 8'h42, 1'b0);
        #1;
        grant_outs("t1_b1", 2, 8'h42, 4'b0100);
        tick();
        put(2, 1'b1, 8'h43, 1'b1);
        #1;
        grant_outs("t1_b2", 2, 8'h43, 4'b0100);
        tick();
        put(2, 1'b0, 8'h00, 1'b0);
        #1;
        idle_outs("t1_rel");
        // rr_ptr is now 3: with 0 and 3 both valid, 3 wins, then 0.
        put(0, 1'b1, 8'h30, 1'b1);
        put(3, 1'b1, 8'h33, 1'b1);
        tick();
        grant_outs("t1_ptr3", 3, 8'h33, 4'b1000);
        tick();
        put(3, 1'b0, 8'h00, 1'b0);
        #1;
        idle_outs("t1_gap");
        tick();
        grant_outs("t1_wrap", 0, 8'h30, 4'b0001);
        tick();
        put(0, 1'b0, 8'h00, 1'b0);
        #1;
        idle_outs("t1_end");

        // ---- round robin, 1-byte messages on all four ----
        do_reset();
        for (int i = 0; i < 4; i++) put(i, 1'b1, 8'(8'h10 + i), 1'b1);
        for (int n = 0; n < 5; n++) begin
            tick();
            id  = n % 4;
            rdy = 4'b0001 << id;
            grant_outs($sformatf("rr%0d", n), id, 8'(8'h10 + id), rdy);
            tick();
            check($sformatf("rr_gap%0d", n), 32'(gnt_valid), 32'd0);
        end
        req_valid = '0;
        req_last  = '0;
        req_bits  = '0;

        // ---- burst limit: req 1 streams 20 bytes, req 3 waiting ----
        do_reset();
        put(1, 1'b1, 8'hA0, 1'b0);
        put(3, 1'b1, 8'h77, 1'b1);
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) #1;
            grant_outs($sformatf("bl_b%0d", k), 1, 8'(8'hA0 + k), 4'b0010);
            tick();
            put(1, 1'b1, 8'(8'hA0 + k + 1), 1'b0);
        end
        #1;
        check("bl_release", 32'(gnt_valid), 32'd0);
        tick();
        grant_outs("bl_other", 3, 8'h77, 4'b1000);
        tick();
        put(3, 1'b0, 8'h00, 1'b0);
        #1;
        check("bl_gap", 32'(gnt_valid), 32'd0);
        tick();
        for (int k = 16; k < 20; k++) begin
            if (k > 16) #1;
            grant_outs($sformatf("bl_b%0d", k), 1, 8'(8'hA0 + k), 4'b0010);
            tick();
            if (k < 19) put(1, 1'b1, 8'(8'hA0 + k + 1), (k + 1 == 19));
            else        put(1, 1'b0, 8'h00, 1'b0);
        end
        #1;
        idle_outs("bl_end");

        // ---- back-pressure: ready 1,0,0,1 over a 2-byte message (rr_ptr=2) ----
        put(0, 1'b1, 8'h55, 1'b0);
        tick();
        grant_outs("bp0", 0, 8'h55, 4'b0001);
        tick();
        put(0, 1'b1, 8'h66, 1'b1);
        enq_ready = 1'b0;
        put(3, 1'b1, 8'hEE, 1'b1);
        #1;
        grant_outs("bp1", 0, 8'h66, 4'b0000);
        tick();
        put(3, 1'b1, 8'hDD, 1'b0);
        #1;
        grant_outs("bp2", 0, 8'h66, 4'b0000);
        put(3, 1'b0, 8'h00, 1'b0);
        tick();
        enq_ready = 1'b1;
        #1;
        grant_outs("bp3", 0, 8'h66, 4'b0001);
        tick();
        put(0, 1'b0, 8'h00, 1'b0);
        #1;
        idle_outs("bp_rel");
        tick();
        idle_outs("bp_quiet");

        // ---- idle timeout: req 0 stalls mid-message, req 3 pending ----
        do_reset();
        put(0, 1'b1, 8'h99, 1'b0);
        put(3, 1'b1, 8'h3C, 1'b1);
        tick();
        grant_outs("to_b0", 0, 8'h99, 4'b0001);
        tick();
        put(0, 1'b0, 8'h00, 1'b0);
        #1;
        for (int i = 1; i <= 64; i++) begin
            if (i == 1 || i == 63 || i == 64) begin
                check($sformatf("to_hold%0d.gnt_valid", i), 32'(gnt_valid), 32'd1);
                check($sformatf("to_hold%0d.gnt_id", i),    32'(gnt_id),    32'd0);
                check($sformatf("to_hold%0d.enq_valid", i), 32'(enq_valid), 32'd0);
            end
            tick();
        end
        idle_outs("to_rel");
        tick();
        grant_outs("to_next", 3, 8'h3C, 4'b1000);
        tick();
        put(3, 1'b0, 8'h00, 1'b0);
        #1;
        idle_outs("to_end");

        // ---- reset mid-message; rr_ptr moved to 2 beforehand ----
        put(1, 1'b1, 8'hB1, 1'b1);
        tick();
        grant_outs("rm_pre", 1, 8'hB1, 4'b0010);
        tick();
        put(1, 1'b0, 8'h00, 1'b0);
        put(2, 1'b1, 8'hE1, 1'b0);
        tick();
        grant_outs("rm_g", 2, 8'hE1, 4'b0100);
        tick();
        put(2, 1'b1, 8'hE2, 1'b0);
        #1;
        grant_outs("rm_b1", 2, 8'hE2, 4'b0100);
        reset = 1'b0;
        #1;
        idle_outs("rm_async");
        put(0, 1'b1, 8'h0F, 1'b1);
        tick();
        idle_outs("rm_held");
        reset = 1'b1;
        #1;
        idle_outs("rm_after");
        tick();
        grant_outs("rm_first", 0, 8'h0F, 4'b0001);
        tick();
        req_valid = '0;
        req_last  = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
